// File: rtl/dram_traffic_checker_if.sv
// Wishbone-classic user-port bundle between the traffic checker (master) and the DRAM wrapper (slave).
interface dram_traffic_checker_if #(
    parameter int WORD_SIZE = 256
) ();
    logic                 cyc_o;
    logic                 stb_o;
    logic                 we_o;
    logic [31:0]          addr_o;
    logic [WORD_SIZE-1:0] data_o;
    logic [WORD_SIZE-1:0] data_i;
    logic                 ack_i;

    modport master (output cyc_o, stb_o, we_o, addr_o, data_o, input data_i, ack_i);
    modport slave  (input cyc_o, stb_o, we_o, addr_o, data_o, output data_i, ack_i);
endinterface

// File: rtl/dram_traffic_checker.sv
// DRAM traffic generator/checker: writes a pattern over a word range, reads it back and reports errors.
// Optional macro TRAFFIC_CONTINUOUS_EN: auto-restart after passing runs and count completed loops.
module dram_traffic_checker #(
    parameter int          WORD_SIZE      = 256,
    parameter int          ADDR_WIDTH     = 25,
    parameter int          ADDR_LSB       = 7,
    parameter int          NUM_WORDS      = 1024,
    parameter int          BASE_WORD      = 0,
    parameter logic [31:0] LFSR_SEED      = 32'hACE1_2024,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  initialized,
    input  logic                  start_i,
    input  logic [1:0]            pattern_sel_i,
    dram_traffic_checker_if.master wb,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [15:0]           err_count_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o,
`ifdef TRAFFIC_CONTINUOUS_EN
    output logic [15:0]           loop_count_o,
`endif
    output logic [7:0]            led
);
    localparam int          LANES  = WORD_SIZE / 32;
    localparam int          WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] TAPS   = 32'h8020_0003;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_INIT, S_WR_REQ, S_WR_GAP, S_RD_REQ, S_RD_GAP, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [31:0]           lfsr_q, lfsr_d;
    logic [1:0]            mode_q, mode_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [15:0]           err_q, err_d;
    logic [ADDR_WIDTH-1:0] first_q, first_d;
    logic                  timeout_q, timeout_d;
`ifdef TRAFFIC_CONTINUOUS_EN
    logic [15:0]           loop_q, loop_d;
`endif

    logic                  restart;
    logic                  req;
    logic                  last_word;
    logic                  expired;
    logic [1:0]            sel_mode;
    logic [31:0]           idx_ext;
    logic [31:0]           lfsr_next;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [WORD_SIZE-1:0]  walk_word;
    logic [WORD_SIZE-1:0]  pattern;

    assign sel_mode  = (pattern_sel_i == 2'd3) ? 2'd0 : pattern_sel_i;
    assign idx_ext   = 32'(idx_q);
    assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);
    assign word_addr = ADDR_WIDTH'(BASE_WORD) + idx_q;
    assign last_word = (idx_q == ADDR_WIDTH'(NUM_WORDS - 1));
    assign expired   = (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
    assign walk_word = {{(WORD_SIZE-1){1'b0}}, 1'b1} << (idx_ext % 32'(WORD_SIZE));

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign pattern[gi*32 +: 32] = (mode_q == 2'd1) ? (lfsr_q ^ 32'(gi)) :
                                          (mode_q == 2'd2) ? walk_word[gi*32 +: 32] :
                                                             (idx_ext + 32'(gi));
        end
    endgenerate

    // Bus outputs decode straight from state so an async reset drops cyc/stb at once.
    assign req       = (state_q == S_WR_REQ) || (state_q == S_RD_REQ);
    assign wb.cyc_o  = req;
    assign wb.stb_o  = req;
    assign wb.we_o   = (state_q == S_WR_REQ);
    assign wb.addr_o = req ? (32'(word_addr) << ADDR_LSB) : 32'h0;
    assign wb.data_o = (state_q == S_WR_REQ) ? pattern : '0;

    assign busy_o           = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o           = (state_q == S_DONE);
    assign pass_o           = done_o && (err_q == 16'h0) && !timeout_q;
    assign timeout_o        = timeout_q;
    assign err_count_o      = err_q;
    assign first_err_addr_o = first_q;
    assign led              = {timeout_o, pass_o, done_o, busy_o, 3'b000, initialized};
`ifdef TRAFFIC_CONTINUOUS_EN
    assign loop_count_o     = loop_q;
`endif

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            lfsr_q    <= LFSR_SEED;
            mode_q    <= 2'd0;
            wait_q    <= '0;
            err_q     <= 16'h0;
            first_q   <= '0;
            timeout_q <= 1'b0;
`ifdef TRAFFIC_CONTINUOUS_EN
            loop_q    <= 16'h0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            lfsr_q    <= lfsr_d;
            mode_q    <= mode_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
            first_q   <= first_d;
            timeout_q <= timeout_d;
`ifdef TRAFFIC_CONTINUOUS_EN
            loop_q    <= loop_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lfsr_d    = lfsr_q;
        mode_d    = mode_q;
        wait_d    = wait_q;
        err_d     = err_q;
        first_d   = first_q;
        timeout_d = timeout_q;
        restart   = 1'b0;
`ifdef TRAFFIC_CONTINUOUS_EN
        loop_d    = loop_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    restart = 1'b1;
                    mode_d  = sel_mode;
                end
            end
            S_WAIT_INIT: begin
                wait_d = '0;
                if (initialized) state_d = S_WR_REQ;
            end
            S_WR_REQ: begin
                // Ack wins over a timeout expiring in the same cycle.
                if (wb.ack_i) begin
                    state_d = S_WR_GAP;
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WR_GAP: begin
                wait_d = '0;
                if (last_word) begin
                    idx_d   = '0;
                    lfsr_d  = LFSR_SEED;
                    state_d = S_RD_REQ;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    lfsr_d  = lfsr_next;
                    state_d = S_WR_REQ;
                end
            end
            S_RD_REQ: begin
                if (wb.ack_i) begin
                    state_d = S_RD_GAP;
                    if (wb.data_i != pattern) begin
                        if (err_q != 16'hFFFF) err_d = err_q + 1'b1;
                        if (err_q == 16'h0)    first_d = word_addr;
                    end
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_RD_GAP: begin
                wait_d = '0;
                idx_d  = idx_q + 1'b1;
                lfsr_d = lfsr_next;
                if (last_word) begin
                    state_d = S_DONE;
`ifdef TRAFFIC_CONTINUOUS_EN
                    if (err_q == 16'h0 && loop_q != 16'hFFFF) loop_d = loop_q + 1'b1;
`endif
                end else begin
                    state_d = S_RD_REQ;
                end
            end
            S_DONE: begin
                if (start_i) begin
                    restart = 1'b1;
                    mode_d  = sel_mode;
                end
`ifdef TRAFFIC_CONTINUOUS_EN
                else if (pass_o) begin
                    restart = 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (restart) begin
            idx_d     = '0;
            lfsr_d    = LFSR_SEED;
            err_d     = 16'h0;
            first_d   = '0;
            timeout_d = 1'b0;
            wait_d    = '0;
            state_d   = S_WAIT_INIT;
        end
    end
endmodule

// File: tb/tb_dram_traffic_checker.sv
// Bench for dram_traffic_checker: table-driven runs, random runs and hand sequences against an ideal memory.
module tb_dram_traffic_checker;
    localparam int          WS   = 256;
    localparam int          AW   = 25;
    localparam int          LSB  = 7;
    localparam int          NW   = 16;
    localparam int          TO   = 64;
    localparam logic [31:0] SEED = 32'hACE1_2024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          initialized = 1'b1;
    logic          start_i = 1'b0;
    logic [1:0]    pattern_sel_i = 2'd0;
    logic          busy_o, done_o, pass_o, timeout_o;
    logic [15:0]   err_count_o;
    logic [AW-1:0] first_err_addr_o;
    logic [7:0]    led;
`ifdef TRAFFIC_CONTINUOUS_EN
    logic [15:0]   loop_count_o;
`endif

    dram_traffic_checker_if #(.WORD_SIZE(WS)) wb_if ();

    dram_traffic_checker #(
        .WORD_SIZE(WS), .ADDR_WIDTH(AW), .ADDR_LSB(LSB), .NUM_WORDS(NW),
        .BASE_WORD(0), .LFSR_SEED(SEED), .TIMEOUT_CYCLES(TO)
    ) dut (
        .sys_clk(clk), .rst_n(rst_n), .initialized(initialized),
        .start_i(start_i), .pattern_sel_i(pattern_sel_i), .wb(wb_if),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
        .err_count_o(err_count_o), .first_err_addr_o(first_err_addr_o),
`ifdef TRAFFIC_CONTINUOUS_EN
        .loop_count_o(loop_count_o),
`endif
        .led(led)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference patterns, computed directly from the pattern rules.
    function automatic logic [31:0] lfsr_at(input int n);
        logic [31:0] l = SEED;
        for (int s = 0; s < n; s++) l = (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
        return l;
    endfunction

    function automatic logic [WS-1:0] pat(input int mode, input int idx);
        logic [WS-1:0] w = '0;
        if (mode == 2) begin
            w[idx % WS] = 1'b1;
        end else begin
            for (int k = 0; k < WS / 32; k++)
                w[k*32 +: 32] = (mode == 1) ? (lfsr_at(idx) ^ 32'(k)) : (32'(idx) + 32'(k));
        end
        return w;
    endfunction

    // Ideal memory: ack after a programmable latency, optional per-word read corruption.
    logic [WS-1:0] mem  [NW];
    logic [WS-1:0] flip [NW];
    bit            rand_lat = 1'b0;
    bit            withhold = 1'b0;
    int            tb_mode = 0;
    int            wr_cnt = 0, rd_cnt = 0, mdl_bad = 0;
    int            wr_base = 0, rd_base = 0, bad_base = 0;
    int            lat_cnt = 0, lat_tgt = 0;
    logic [31:0]   wr_addr0, wr_addr1, wr_lane0;

    always @(negedge clk) begin : mem_model
        int w;
        int n;
        wb_if.ack_i = 1'b0;
        if (wb_if.cyc_o && wb_if.stb_o) begin
            w = int'(wb_if.addr_o >> LSB);
            if (withhold && wb_if.we_o && w == 2) begin
                lat_cnt = 0;
            end else if (lat_cnt >= lat_tgt) begin
                lat_cnt = 0;
                lat_tgt = rand_lat ? int'($urandom_range(19, 0)) : 0;
                wb_if.ack_i = 1'b1;
                if (wb_if.we_o) begin
                    n = wr_cnt - wr_base;
                    if (n == 0) begin wr_addr0 = wb_if.addr_o; wr_lane0 = wb_if.data_o[31:0]; end
                    if (n == 1) wr_addr1 = wb_if.addr_o;
                    if (w != n % NW || wb_if.data_o !== pat((tb_mode == 3) ? 0 : tb_mode, w)) mdl_bad++;
                    mem[w % NW] = wb_if.data_o;
                    wr_cnt++;
                    $display("WR n=%0d addr=%h lane0=%h", n, wb_if.addr_o, wb_if.data_o[31:0]);
                end else begin
                    n = rd_cnt - rd_base;
                    if (w != n % NW) mdl_bad++;
                    wb_if.data_i = mem[w % NW] ^ flip[w % NW];
                    rd_cnt++;
                    $display("RD n=%0d addr=%h lane0=%h", n, wb_if.addr_o, wb_if.data_i[31:0]);
                end
            end else begin
                lat_cnt++;
            end
        end else begin
            lat_cnt = 0;
        end
    end

    typedef struct {
        int         mode;
        bit         rl;
        int         flip_idx;
        int         exp_err;
        int         exp_first;
        bit         exp_pass;
        logic [7:0] exp_led;
        bit         chk_addr;
        bit         chk_seed;
    } vec_t;
    vec_t tbl[6];

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic prep(input int mode, input bit rl);
        do_reset();
        tb_mode  = mode;
        rand_lat = rl;
        withhold = 1'b0;
        wr_base  = wr_cnt;
        rd_base  = rd_cnt;
        bad_base = mdl_bad;
    endtask

    task automatic pulse_start(input int mode);
        @(negedge clk);
        start_i = 1'b1;
        pattern_sel_i = 2'(mode);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            @(negedge clk);
            if (done_o) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_done actual=0 required=1 within 20000 cycles", nm);
        end
    endtask

    task automatic run_one(input string nm, input int mode, input bit rl, input int exp_err,
                           input int exp_first, input bit exp_pass, input logic [7:0] exp_led);
        bit ok;
        prep(mode, rl);
        pulse_start(mode);
        wait_done(nm, ok);
        if (ok) begin
            chk({nm, "_err"}, err_count_o, exp_err);
            chk({nm, "_first"}, first_err_addr_o, exp_first);
            chk({nm, "_pass"}, pass_o, exp_pass);
            chk({nm, "_timeout"}, timeout_o, 0);
            chk({nm, "_led"}, led, exp_led);
            chk({nm, "_nwr"}, wr_cnt - wr_base, NW);
            chk({nm, "_nrd"}, rd_cnt - rd_base, NW);
            chk({nm, "_model"}, mdl_bad - bad_base, 0);
        end
        $display("RUN %s mode=%0d err=%0d first=%0d pass=%0d led=%b", nm, mode, err_count_o,
                 first_err_addr_o, pass_o, led);
    endtask

    initial begin
        bit ok;
        int n;
        int exp_err, exp_first, mode;
        for (int w = 0; w < NW; w++) flip[w] = '0;

        repeat (3) @(negedge clk);
        chk("rst_cyc", wb_if.cyc_o, 0);
        chk("rst_stb", wb_if.stb_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_count_o, 0);
        chk("rst_led", led, 8'h01);
        initialized = 1'b0;
        #1 chk("rst_led_init0", led, 8'h00);
        initialized = 1'b1;
        rst_n = 1'b1;

        tbl[0] = '{0, 1'b0, -1, 0, 0,  1'b1, 8'h61, 1'b1, 1'b0};
        tbl[1] = '{0, 1'b0, 5,  1, 5,  1'b0, 8'h21, 1'b0, 1'b0};
        tbl[2] = '{1, 1'b1, -1, 0, 0,  1'b1, 8'h61, 1'b0, 1'b1};
        tbl[3] = '{2, 1'b1, -1, 0, 0,  1'b1, 8'h61, 1'b0, 1'b0};
        tbl[4] = '{3, 1'b0, 15, 1, 15, 1'b0, 8'h21, 1'b0, 1'b0};
        tbl[5] = '{1, 1'b1, 0,  1, 0,  1'b0, 8'h21, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            for (int w = 0; w < NW; w++) flip[w] = '0;
            if (tbl[i].flip_idx >= 0) flip[tbl[i].flip_idx][3] = 1'b1;
            run_one($sformatf("vec%0d", i), tbl[i].mode, tbl[i].rl, tbl[i].exp_err,
                    tbl[i].exp_first, tbl[i].exp_pass, tbl[i].exp_led);
            if (tbl[i].chk_addr) begin
                chk("first_wr_addr", wr_addr0, 32'h0);
                chk("second_wr_addr", wr_addr1, 32'h80);
            end
            if (tbl[i].chk_seed) chk("lfsr_lane0_idx0", wr_lane0, SEED);
        end

        for (int r = 0; r < 4; r++) begin
            mode = int'($urandom_range(3, 0));
            exp_err = 0;
            exp_first = 0;
            for (int w = 0; w < NW; w++) begin
                flip[w] = '0;
                if ($urandom_range(3, 0) == 0) begin
                    flip[w][$urandom_range(WS - 1, 0)] = 1'b1;
                    if (exp_err == 0) exp_first = w;
                    exp_err++;
                end
            end
            run_one($sformatf("rnd%0d", r), mode, 1'b1, exp_err, exp_first, exp_err == 0,
                    {1'b0, exp_err == 0, 1'b1, 1'b0, 3'b000, 1'b1});
        end
        for (int w = 0; w < NW; w++) flip[w] = '0;

        // Calibration not done: no bus activity until initialized rises.
        prep(0, 1'b0);
        initialized = 1'b0;
        pulse_start(0);
        n = 0;
        repeat (500) begin
            @(negedge clk);
            if (wb_if.cyc_o) n++;
        end
        chk("init_hold_cyc", n, 0);
        chk("init_hold_busy", busy_o, 1);
        initialized = 1'b1;
        wait_done("init_hold", ok);
        if (ok) begin
            chk("init_hold_pass", pass_o, 1);
            chk("init_hold_nwr", wr_cnt - wr_base, NW);
        end
        $display("RUN init_hold pass=%0d", pass_o);

        // Ack withheld on write index 2: cyc must stay up exactly TO cycles.
        prep(0, 1'b0);
        withhold = 1'b1;
        pulse_start(0);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (wb_if.stb_o && wb_if.we_o && wb_if.addr_o == 32'h100) ok = 1'b1;
        end
        chk("timeout_req_seen", ok, 1);
        n = 0;
        while (wb_if.cyc_o && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_cyc_len", n, TO);
        chk("timeout_flag", timeout_o, 1);
        chk("timeout_done", done_o, 1);
        chk("timeout_pass", pass_o, 0);
        chk("timeout_led", led, 8'hA1);
        chk("timeout_nwr", wr_cnt - wr_base, 2);
        repeat (5) @(negedge clk);
        chk("timeout_done_held", done_o, 1);
        withhold = 1'b0;
        $display("RUN timeout cyc_len=%0d", n);

        prep(0, 1'b1);
        pulse_start(0);
`ifdef TRAFFIC_CONTINUOUS_EN
        ok = 1'b0;
        for (int i = 0; i < 30000 && !ok; i++) begin
            @(negedge clk);
            if (loop_count_o == 16'd3) ok = 1'b1;
        end
        chk("loop_count_3", loop_count_o, 3);
`endif
        // Async reset in the middle of a write.
        ok = 1'b0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            if (wb_if.stb_o && wb_if.we_o && (wr_cnt - wr_base) >= 3) ok = 1'b1;
        end
        chk("midwr_seen", ok, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midwr_rst_cyc", wb_if.cyc_o, 0);
        chk("midwr_rst_stb", wb_if.stb_o, 0);
        chk("midwr_rst_busy", busy_o, 0);
        chk("midwr_rst_led", led, 8'h01);
`ifdef TRAFFIC_CONTINUOUS_EN
        chk("midwr_rst_loop", loop_count_o, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        $display("RUN midwrite_reset cyc=%0d busy=%0d", wb_if.cyc_o, busy_o);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dram_traffic_checker.md
Name: dram_traffic_checker

Overview:
- Self-contained DRAM traffic generator and checker. Drives the DRAM wrapper's Wishbone-classic user port (cyc/stb/we/addr/data/ack) from the board top level.
- Writes a parametrised pattern over a configurable word range, reads it back, compares it, and reports pass/fail, error count, first failing address and LED status.
- Successor to the static top-level hookup: the word size, address width, range, pattern mode and ack timeout are all parametrised.

Parameters:
- WORD_SIZE, 256, data width in bits; a multiple of 32.
- ADDR_WIDTH, 25, word-index width.
- ADDR_LSB, 7, zero bits appended below the word index to form the 32-bit byte address; ADDR_WIDTH+ADDR_LSB ≤ 32.
- NUM_WORDS, 1024, words per pass; ≥ 1 and ≤ 2^ADDR_WIDTH.
- BASE_WORD, 0, first word index.
- LFSR_SEED, 32'hACE1_2024, LFSR seed; nonzero.
- TIMEOUT_CYCLES, 4096, maximum cycles to wait for ack.

Ports:
- sys_clk, input, 1, system clock (100 MHz).
- rst_n, input, 1, asynchronous active-low reset.
- initialized, input, 1, DRAM calibration done, from the wrapper.
- start_i, input, 1, single-cycle pulse that begins a run.
- pattern_sel_i, input, 2, 0 = address, 1 = LFSR, 2 = walking-one, 3 = treated as 0; sampled at start.
- cyc_o, output, 1, Wishbone cycle.
- stb_o, output, 1, Wishbone strobe.
- we_o, output, 1, Wishbone write enable.
- addr_o, output, 32, byte address.
- data_o, output, WORD_SIZE, write data.
- data_i, input, WORD_SIZE, read data.
- ack_i, input, 1, Wishbone ack.
- busy_o, output, 1, run in progress.
- done_o, output, 1, run finished.
- pass_o, output, 1, finished with no errors and no timeout.
- timeout_o, output, 1, ack timeout occurred.
- err_count_o, output, 16, saturating mismatch count.
- first_err_addr_o, output, ADDR_WIDTH, word index of the first mismatch.
- led, output, 8, {timeout, pass, done, busy, 3'b0, initialized}.

Behaviour:
- Reset: all outputs 0 except `led[0]`, which follows `initialized`. Counters cleared; FSM in IDLE. Reset mid-transaction drops cyc/stb immediately.
- FSM states: IDLE, WAIT_INIT, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE.
- IDLE: on `start_i`:
  - latch the pattern mode;
  - clear err_count, first_err_addr, timeout, pass, done;
  - set index = 0 and LFSR = LFSR_SEED;
  - go to WAIT_INIT.
- `start_i` is ignored outside IDLE and DONE. In DONE, `start_i` behaves as in IDLE.
- WAIT_INIT: wait for `initialized` = 1, then go to WR_REQ. No timeout in this state.
- WR_REQ: assert cyc=stb=we=1, addr = {BASE_WORD+index, ADDR_LSB zeros}, data = pattern(index). All held stable until `ack_i`.
  - On ack, go to WR_GAP; cyc/stb drop on the next cycle (one idle cycle between transactions).
- WR_GAP: advance the LFSR and increment index.
  - If the last word was written: index = 0, LFSR = seed, go to RD_REQ.
  - Otherwise go to WR_REQ.
- RD_REQ: cyc=stb=1, we=0, same address rule. On ack, compare `data_i` with pattern(index) in the same cycle.
  - On mismatch: err_count += 1, saturating at 16'hFFFF. first_err_addr is captured only on the first mismatch.
- RD_GAP: advance the LFSR and increment index. After the last word go to DONE, otherwise go to RD_REQ.
- Timeout: the wait counter resets on entry to each *_REQ state. If ack is absent for TIMEOUT_CYCLES cycles:
  - set `timeout_o`, drop cyc/stb, go to DONE with pass = 0.
  - Ack arriving in the same cycle as expiry counts as ack.
- DONE: done=1, busy=0, pass = (err_count==0 && !timeout). Held until `start_i`.
- busy_o = 1 in WAIT_INIT through RD_GAP.
- Index width is ADDR_WIDTH; BASE_WORD+index wraps modulo 2^ADDR_WIDTH.
- Patterns, per 32-bit lane k:
  - address mode: lane = index + k;
  - LFSR mode: lane = lfsr ^ k. The LFSR is a 32-bit Galois LFSR (taps 0x80200003) advanced once per word; the same sequence is replayed on read.
  - walking-one mode: only bit (index mod WORD_SIZE) of the word is set.
- `ack_i` outside a request state is ignored.

Optional Feature:
- Macro: TRAFFIC_CONTINUOUS_EN.
- Defined:
  - DONE with pass=1 auto-restarts after one cycle with the same mode;
  - a 16-bit saturating loop counter (port `loop_count_o`, 16 bits, reset 0) increments per completed passing loop;
  - a failure or timeout stops in DONE.
- Undefined: port absent; DONE waits for `start_i`.

Test Plan:
- Ideal memory model with 1-cycle ack, NUM_WORDS=16, mode 0, start → 16 writes then 16 reads; addr_o of the first write = 0x0, of the second = 0x80; done=1, pass=1, err_count=0, led=8'b0110_0001.
- Memory model flipping bit 3 of word 5 on read → err_count=1, first_err_addr=5, pass=0.
- `initialized` held 0 for 500 cycles after start → no cyc_o during that time; run completes normally once it rises.
- ack withheld on write index 2, TIMEOUT_CYCLES=64 → cyc drops 64 cycles after stb rises; timeout=1, done=1, pass=0.
- LFSR mode, random ack latency 1–20 cycles → pass=1; write data at index 0, lane 0 = 32'hACE1_2024.
- TRAFFIC_CONTINUOUS_EN, 3 clean loops → loop_count_o=3; asserting rst_n=0 mid-write clears cyc_o, stb_o and all status asynchronously.
